key_code_assembler: RTL and testbench
=====================================

KEY_CODE_ASSEMBLER -- requirements
Module: key_code_assembler

Interface
REQ-001 SHALL have parameter NKEYS, default 2: number of digit keys; key i enters digit value i (NKEYS >= 2).
REQ-002 SHALL have parameter DIGITS, default 4: digits per complete code (DIGITS >= 1).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 1000000: idle-entry timeout in clock cycles (>= 2).
REQ-004 SHALL derive DW = $clog2(NKEYS) as the digit width and CW = $clog2(DIGITS+1) as the count width.
REQ-005 SHALL have clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have keypad, input, NKEYS+2: raw asynchronous keys; bits [NKEYS-1:0] are digit keys, bit NKEYS is DEL, bit NKEYS+1 is CLR.
REQ-008 SHALL have code_ready, input, 1: consumer accepts code.
REQ-009 SHALL have code, output, DIGITS*DW: assembled code; the oldest digit is in the MSBs.
REQ-010 SHALL have code_valid, output, 1: code is complete and held.
REQ-011 SHALL have count, output, CW: number of digits entered.
REQ-012 SHALL have timeout, output, 1: one-cycle pulse when an entry is abandoned.

Function
REQ-013 SHALL pass keypad through a 2-flop synchronizer followed by one delay flop (prev).
REQ-014 SHALL generate strobe = (|sync) & ~(|prev): the press edge of the keypad as a whole; held keys SHALL NOT repeat.
REQ-015 SHALL accept a strobe only if exactly one bit of sync is set; multi-bit strobes are ignored with no state change.
REQ-016 SHALL implement states IDLE (count 0), ENTRY (0 < count < DIGITS) and FULL (count == DIGITS).
REQ-017 On an accepted digit key k in IDLE or ENTRY, SHALL set code = {code[DIGITS*DW-DW-1:0], k[DW-1:0]} and count = count+1.
REQ-018 On DEL in ENTRY, SHALL shift code right by DW, zero-fill the MSBs and decrement count; a transition to IDLE occurs when count reaches 0.
REQ-019 SHALL ignore DEL in IDLE and FULL.
REQ-020 On CLR in any state, SHALL clear code and count to 0 and enter IDLE.
REQ-021 SHALL assert code_valid exactly while in FULL; code SHALL be stable while code_valid is high.
REQ-022 SHALL ignore digit keys in FULL.
REQ-023 On code_valid & code_ready, SHALL clear code and count and enter IDLE on the next edge.
REQ-024 A handshake and a CLR in the same cycle SHALL be treated as a completed handshake; the resulting state is IDLE in both cases.
REQ-025 Latency: a key first sampled at edge E0 SHALL update code and count at edge E0+3 and remain updated after it.
REQ-026 The DIGITS-th digit SHALL raise code_valid on the same edge that count reaches DIGITS.

Reset
REQ-027 While rst is high at a clock edge, SHALL clear the synchronizer, prev, code, count and timer, and enter IDLE.
REQ-028 SHALL drive code_valid = 0 and timeout = 0 during and after reset.
REQ-029 Reset mid-entry or in FULL SHALL discard the partial or complete code with no handshake.
REQ-030 A key held through reset release SHALL NOT produce a strobe.

Configuration
REQ-031 With KEY_TIMEOUT_EN defined, SHALL count cycles spent in ENTRY and reset the counter on every accepted strobe.
REQ-032 With KEY_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC, SHALL clear code and count, enter IDLE and pulse timeout high for one cycle.
REQ-033 With KEY_TIMEOUT_EN defined, SHALL NOT run the timer in IDLE or FULL.
REQ-034 With KEY_TIMEOUT_EN undefined, SHALL omit the timer logic and tie timeout to 0; all other behaviour is unchanged.

Verification
REQ-035 NKEYS=2, DIGITS=4: press 1,0,1,1 with code_ready=0 -> code=4'b1011, count=4, code_valid=1 held; then code_ready=1 for one cycle -> next cycle code=0, count=0, code_valid=0.
REQ-036 NKEYS=10, DIGITS=3: press 7, 2, DEL, 5, 9 -> code={4'd7, 4'd5, 4'd9}, code_valid=1; the DEL step shows count 2 -> 1 and code 0x072 -> 0x007.
REQ-037 Press keys 0 and 1 simultaneously, then CLR after 2 digits, then DEL at count 0 -> first press no change, CLR gives count=0 and code=0, DEL no change.
REQ-038 Hold key 1 for 50 cycles; also press while in FULL -> exactly one digit is entered; the FULL press leaves code unchanged.
REQ-039 Assert rst for one cycle at count=2 while a key is held -> count=0 and code_valid=0; no digit is entered until the key is released and pressed again.
REQ-040 KEY_TIMEOUT_EN, TIMEOUT_CYC=16: enter one digit, then idle -> timeout pulses exactly once, 16 cycles after the digit update, and count=0; the same stimulus without the macro keeps count=1 indefinitely.

Source files
------------

// File: rtl/key_code_assembler.sv
// Keypad code assembler: synchronized, edge-detected key entry into a code register.
// Define KEY_TIMEOUT_EN to abandon entries left idle for TIMEOUT_CYC cycles.
module key_code_assembler #(
  parameter int NKEYS       = 2,
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int DW = $clog2(NKEYS),
  localparam int CW = $clog2(DIGITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NKEYS+1:0]     keypad,
  input  logic                 code_ready,
  output logic [DIGITS*DW-1:0] code,
  output logic                 code_valid,
  output logic [CW-1:0]        count,
  output logic                 timeout
);

  localparam int KW = NKEYS + 2;
  localparam int XW = DIGITS * DW;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    FULL
  } state_t;

  logic [KW-1:0] meta, sync, prev;
  logic          live, armed;
  logic          strobe, accept;
  logic [DW-1:0] key_idx;
  logic          ev_dig, ev_del, ev_clr;
  logic [DW-1:0] ev_key;

  state_t        state, state_n;
  logic [XW-1:0] code_q, code_n;
  logic [CW-1:0] count_q, count_n;

  // armed stays low until the synchronizer has seen an empty keypad after
  // reset, so a key held through reset release never strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= '0;
      sync  <= '0;
      prev  <= '0;
      live  <= 1'b0;
      armed <= 1'b0;
    end else begin
      meta  <= keypad;
      sync  <= meta;
      prev  <= sync;
      live  <= 1'b1;
      armed <= armed | (live & ~|meta);
    end
  end

  assign strobe = armed & (|sync) & ~(|prev);
  assign accept = strobe & $onehot(sync);

  always_comb begin
    key_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (sync[i]) key_idx = DW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ev_dig <= 1'b0;
      ev_del <= 1'b0;
      ev_clr <= 1'b0;
      ev_key <= '0;
    end else begin
      ev_dig <= accept & (|sync[NKEYS-1:0]);
      ev_del <= accept & sync[NKEYS];
      ev_clr <= accept & sync[NKEYS+1];
      ev_key <= key_idx;
    end
  end

`ifdef KEY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] timer, timer_n;
  logic          fire, timeout_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      code_q  <= '0;
      count_q <= '0;
`ifdef KEY_TIMEOUT_EN
      timer     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      code_q  <= code_n;
      count_q <= count_n;
`ifdef KEY_TIMEOUT_EN
      timer     <= timer_n;
      timeout_q <= fire;
`endif
    end
  end

  always_comb begin
    state_n = state;
    code_n  = code_q;
    count_n = count_q;
`ifdef KEY_TIMEOUT_EN
    fire    = 1'b0;
`endif
    if (state == FULL && code_ready) begin
      state_n = IDLE;
      code_n  = '0;
      count_n = '0;
    end else if (ev_clr) begin
      state_n = IDLE;
      code_n  = '0;
      count_n = '0;
    end else if (ev_dig && state != FULL) begin
      code_n  = (code_q << DW) | XW'(ev_key);
      count_n = count_q + CW'(1);
      state_n = (count_q == CW'(DIGITS - 1)) ? FULL : ENTRY;
    end else if (ev_del && state == ENTRY) begin
      code_n  = code_q >> DW;
      count_n = count_q - CW'(1);
      state_n = (count_q == CW'(1)) ? IDLE : ENTRY;
`ifdef KEY_TIMEOUT_EN
    end else if (state == ENTRY && timer == TW'(TIMEOUT_CYC - 1)) begin
      state_n = IDLE;
      code_n  = '0;
      count_n = '0;
      fire    = 1'b1;
`endif
    end
`ifdef KEY_TIMEOUT_EN
    timer_n = '0;
    if (state == ENTRY && state_n == ENTRY &&
        !(ev_dig || ev_del || ev_clr))
      timer_n = timer + TW'(1);
`endif
  end

  always_comb begin
    code       = code_q;
    count      = count_q;
    code_valid = (state == FULL);
`ifdef KEY_TIMEOUT_EN
    timeout    = timeout_q;
`else
    timeout    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_code_assembler.sv
// Bench for key_code_assembler: a 2-key/4-digit and a 10-key/3-digit instance.
// Table-driven presses with a scoreboard queue, plus latency/reset/hold/timeout sequences.
module tb_key_code_assembler;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [3:0]  kp_a;
  logic [11:0] kp_b;
  logic        rdy_a, rdy_b;
  logic [3:0]  code_a;
  logic [11:0] code_b;
  logic [2:0]  count_a;
  logic [1:0]  count_b;
  logic        valid_a, valid_b, to_a, to_b;

  always #5 clk = ~clk;

  key_code_assembler #(.NKEYS(2), .DIGITS(4), .TIMEOUT_CYC(16)) u_a (
    .clk(clk), .rst(rst_a), .keypad(kp_a), .code_ready(rdy_a),
    .code(code_a), .code_valid(valid_a), .count(count_a), .timeout(to_a)
  );

  key_code_assembler #(.NKEYS(10), .DIGITS(3), .TIMEOUT_CYC(1000000)) u_b (
    .clk(clk), .rst(rst_b), .keypad(kp_b), .code_ready(rdy_b),
    .code(code_b), .code_valid(valid_b), .count(count_b), .timeout(to_b)
  );

  typedef struct {
    int          kind;
    bit          b;
    logic [11:0] kp;
    logic [11:0] code;
    int          cnt;
    bit          v;
  } vec_t;

  typedef struct {
    bit          b;
    logic [11:0] code;
    int          cnt;
    bit          v;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;
  int   to_cyc = -1;
  int   upd_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (to_a) begin
      pulses_a++;
      to_cyc = cyc;
    end
    if (to_b) pulses_b++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(int kind, bit b, logic [11:0] kp,
                              logic [11:0] code, int cnt, bit v);
    vec_t t;
    t.kind = kind;
    t.b    = b;
    t.kp   = kp;
    t.code = code;
    t.cnt  = cnt;
    t.v    = v;
    return t;
  endfunction

  task automatic press(input bit b, input logic [11:0] kp, input int hold);
    @(negedge clk);
    if (b) kp_b = kp;
    else kp_a = kp[3:0];
    repeat (hold) @(negedge clk);
    kp_a = '0;
    kp_b = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [11:0] gc;
    int          gn;
    bit          gv;
    e  = sb.pop_front();
    gc = e.b ? code_b : {8'b0, code_a};
    gn = e.b ? int'(count_b) : int'(count_a);
    gv = e.b ? valid_b : valid_a;
    chk($sformatf("code[%0d]", e.idx), {20'b0, gc}, {20'b0, e.code});
    chk($sformatf("count[%0d]", e.idx), gn, e.cnt);
    chk($sformatf("valid[%0d]", e.idx), {31'b0, gv}, {31'b0, e.v});
  endtask

  task automatic expect_now(input int idx, input bit b, input logic [11:0] code,
                            input int cnt, input bit v);
    exp_t e;
    e.b    = b;
    e.code = code;
    e.cnt  = cnt;
    e.v    = v;
    e.idx  = idx;
    sb.push_back(e);
  endtask

  initial begin
    tbl.push_back(mk(0, 0, 12'h002, 12'h001, 1, 0));
    tbl.push_back(mk(0, 0, 12'h001, 12'h002, 2, 0));
    tbl.push_back(mk(0, 0, 12'h002, 12'h005, 3, 0));
    tbl.push_back(mk(0, 0, 12'h002, 12'h00B, 4, 1));
    tbl.push_back(mk(0, 0, 12'h001, 12'h00B, 4, 1));
    tbl.push_back(mk(0, 0, 12'h004, 12'h00B, 4, 1));
    tbl.push_back(mk(1, 0, 12'h000, 12'h000, 0, 0));
    tbl.push_back(mk(0, 1, 12'h080, 12'h007, 1, 0));
    tbl.push_back(mk(0, 1, 12'h004, 12'h072, 2, 0));
    tbl.push_back(mk(0, 1, 12'h400, 12'h007, 1, 0));
    tbl.push_back(mk(0, 1, 12'h020, 12'h075, 2, 0));
    tbl.push_back(mk(0, 1, 12'h200, 12'h759, 3, 1));
    tbl.push_back(mk(0, 1, 12'h800, 12'h000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h003, 12'h000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h002, 12'h001, 1, 0));
    tbl.push_back(mk(0, 0, 12'h001, 12'h002, 2, 0));
    tbl.push_back(mk(0, 0, 12'h008, 12'h000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h004, 12'h000, 0, 0));
    tbl.push_back(mk(0, 0, 12'h002, 12'h001, 1, 0));
    tbl.push_back(mk(0, 0, 12'h002, 12'h003, 2, 0));
    tbl.push_back(mk(0, 0, 12'h004, 12'h001, 1, 0));
    tbl.push_back(mk(0, 0, 12'h004, 12'h000, 0, 0));

    rst_a = 1'b1;
    rst_b = 1'b1;
    kp_a  = '0;
    kp_b  = '0;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_code_a", {28'b0, code_a}, 32'd0);
    chk("rst_count_a", {29'b0, count_a}, 32'd0);
    chk("rst_valid_a", {31'b0, valid_a}, 32'd0);
    chk("rst_to_a", {31'b0, to_a}, 32'd0);
    chk("rst_code_b", {20'b0, code_b}, 32'd0);
    chk("rst_valid_b", {31'b0, valid_b}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (4) @(negedge clk);

    foreach (tbl[i]) begin
      expect_now(i, tbl[i].b, tbl[i].code, tbl[i].cnt, tbl[i].v);
      if (tbl[i].kind == 0) begin
        press(tbl[i].b, tbl[i].kp, 3);
      end else begin
        @(negedge clk);
        if (tbl[i].b) rdy_b = 1'b1;
        else rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        rdy_b = 1'b0;
      end
      pop_check();
    end

    // a key held for 50 cycles enters exactly one digit
    expect_now(100, 1, 12'h001, 1, 0);
    press(1, 12'h002, 50);
    pop_check();
    expect_now(101, 1, 12'h000, 0, 0);
    press(1, 12'h800, 3);
    pop_check();

    // reset mid-entry with a key held through release
    expect_now(102, 1, 12'h003, 1, 0);
    press(1, 12'h008, 3);
    pop_check();
    expect_now(103, 1, 12'h034, 2, 0);
    press(1, 12'h010, 3);
    pop_check();
    @(negedge clk);
    kp_b  = 12'h020;
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    repeat (10) @(negedge clk);
    expect_now(104, 1, 12'h000, 0, 0);
    pop_check();
    kp_b = '0;
    repeat (6) @(negedge clk);
    expect_now(105, 1, 12'h000, 0, 0);
    pop_check();
    expect_now(106, 1, 12'h005, 1, 0);
    press(1, 12'h020, 3);
    pop_check();

    // latency: sampled at E0, visible after E0+3, then idle for the timer
    @(negedge clk);
    kp_a = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_pre", {29'b0, count_a}, 32'd0);
    @(posedge clk);
    #1;
    chk("lat_post", {29'b0, count_a}, 32'd1);
    upd_cyc = cyc;
    @(negedge clk);
    kp_a = '0;
    repeat (40) @(negedge clk);
`ifdef KEY_TIMEOUT_EN
    chk("to_count", {29'b0, count_a}, 32'd0);
    chk("to_pulses", pulses_a, 32'd1);
    chk("to_delay", to_cyc - upd_cyc, 32'd16);
`else
    chk("noto_count", {29'b0, count_a}, 32'd1);
    chk("noto_pulses", pulses_a, 32'd0);
`endif
    chk("to_b_pulses", pulses_b, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
